// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory interface.
//   ramstate_t  : handshake state reported by the RAM model/controller
//   arb_state_t : cache_mem_arbiter grant FSM states
//   WD_W        : width of the serve-state watchdog counter
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam int WD_W = 8;

endpackage

// File: rtl/mem_watchdog.sv
// Serve-state watchdog for the memory arbiter.
// Counts cycles spent serving a word without RAM ACCESS; saturates at TIMEOUT.
//   CLK, nRST : clock, async active-low reset
//   clear     : zero the count (ACCESS seen, grant changed, or not serving)
//   en        : count this cycle (arbiter is in a serve state)
//   timeout   : count has reached TIMEOUT
module mem_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int W       = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic en,
  output logic timeout
);

  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] wd_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      wd_cnt <= '0;
    else if (clear)
      wd_cnt <= '0;
    else if (en && (wd_cnt != LIMIT))
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = (wd_cnt == LIMIT);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Cache-to-RAM arbiter: serializes icache (read) and dcache (read/write)
// word requests onto one RAM port. Dcache has priority and keeps its grant
// for BLOCK_WORDS accesses so a block's words are not split; a pending
// icache request then gets the next grant. A watchdog aborts a stalled word
// and raises the sticky mem_err; the pending request simply re-arbitrates.
// Ports:
//   CLK, nRST                  : clock, async active-low reset
//   iREN, iaddr / iwait, iload : icache request / response
//   dREN, dWEN, daddr, dstore  : dcache request (dWEN wins over dREN)
//   dwait, dload               : dcache response
//   ramREN, ramWEN, ramaddr, ramstore / ramload, ramstate : RAM port
//   mem_err                    : sticky error (timeout or RAM ERROR)
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam int BC_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BLOCK_WORDS - 1);

  arb_state_t      state, next_state;
  logic [BC_W-1:0] burst_cnt, burst_nxt;
  ramstate_t       rs;
  logic            dreq, access, ram_err, serving, timeout, wd_clear;

  assign rs      = ramstate_t'(ramstate);
  assign dreq    = dREN | dWEN;
  assign access  = (rs == ACCESS);
  assign ram_err = (rs == ERROR);
  assign serving = (state == DSERV) || (state == ISERV);
  // Any grant change restarts the stall count for the new owner.
  assign wd_clear = access || (next_state != state) || !serving;

  mem_watchdog #(.TIMEOUT(TIMEOUT), .W(WD_W)) u_wd (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (wd_clear),
    .en      (serving),
    .timeout (timeout)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      burst_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= next_state;
      burst_cnt <= burst_nxt;
      if (state == ABORT) mem_err <= 1'b1;
    end
  end

  // Next-state: a request leaving is checked first, then word completion,
  // and only a cycle without ACCESS can abort.
  always_comb begin
    next_state = state;
    burst_nxt  = '0;
    case (state)
      IDLE: begin
        if (dreq)      next_state = DSERV;
        else if (iREN) next_state = ISERV;
      end
      DSERV: begin
        if (!dreq) begin
          next_state = IDLE;
        end else if (access) begin
          if (burst_cnt == BURST_LAST) begin
            if (iREN) next_state = ISERV;
          end else begin
            burst_nxt = burst_cnt + 1'b1;
          end
        end else if (ram_err || timeout) begin
          next_state = ABORT;
        end else begin
          burst_nxt = burst_cnt;
        end
      end
      ISERV: begin
        if (!iREN)                 next_state = IDLE;
        else if (access)           next_state = dreq ? DSERV : ISERV;
        else if (ram_err || timeout) next_state = ABORT;
      end
      default: next_state = IDLE;
    endcase
  end

  // RAM port / wait mux; requests pass through combinationally while granted.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~access;
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~access;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule
